// File: rtl/morse_stream_decoder.sv
// Morse receiver: times key marks into dots/dashes, detects character and word gaps,
// and decodes to ASCII through a one-entry valid/ready register. MORSE_DIGITS_EN adds 0-9 decode.
module morse_stream_decoder #(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_ELEMS   = 5,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       char_drop
);
  localparam int SEQ_W = (MAX_ELEMS > 5) ? MAX_ELEMS : 5;
  localparam int LEN_W = $clog2(MAX_ELEMS + 1);
  localparam logic [CNT_W-1:0] DASH_TH = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_TH = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_TH = CNT_W'(7 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_ELEMS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MARK = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d, gcnt_q, gcnt_d;
  logic [CNT_W-1:0] mcnt_inc, gcnt_inc;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             word_pend_q, word_pend_d;
  logic [7:0]       char_data_q, char_data_d;
  logic             char_valid_q, char_valid_d;
  logic             char_drop_q, char_drop_d;
  logic             item_vld;
  logic [7:0]       item_data;
  logic [7:0]       dec_char;

  // Sequence decode; bits above len are always zero so full-width compares are exact
  always_comb begin
    dec_char = 8'h3F;
    if (!ovf_q) begin
      case (len_q)
        LEN_W'(1): case (seq_q)
          SEQ_W'(1'b0): dec_char = 8'h45;
          SEQ_W'(1'b1): dec_char = 8'h54;
          default: ;
        endcase
        LEN_W'(2): case (seq_q)
          SEQ_W'(2'b00): dec_char = 8'h49;
          SEQ_W'(2'b01): dec_char = 8'h41;
          SEQ_W'(2'b10): dec_char = 8'h4E;
          SEQ_W'(2'b11): dec_char = 8'h4D;
          default: ;
        endcase
        LEN_W'(3): case (seq_q)
          SEQ_W'(3'b000): dec_char = 8'h53;
          SEQ_W'(3'b001): dec_char = 8'h55;
          SEQ_W'(3'b010): dec_char = 8'h52;
          SEQ_W'(3'b011): dec_char = 8'h57;
          SEQ_W'(3'b100): dec_char = 8'h44;
          SEQ_W'(3'b101): dec_char = 8'h4B;
          SEQ_W'(3'b110): dec_char = 8'h47;
          SEQ_W'(3'b111): dec_char = 8'h4F;
          default: ;
        endcase
        LEN_W'(4): case (seq_q)
          SEQ_W'(4'b0000): dec_char = 8'h48;
          SEQ_W'(4'b0001): dec_char = 8'h56;
          SEQ_W'(4'b0010): dec_char = 8'h46;
          SEQ_W'(4'b0100): dec_char = 8'h4C;
          SEQ_W'(4'b0110): dec_char = 8'h50;
          SEQ_W'(4'b0111): dec_char = 8'h4A;
          SEQ_W'(4'b1000): dec_char = 8'h42;
          SEQ_W'(4'b1001): dec_char = 8'h58;
          SEQ_W'(4'b1010): dec_char = 8'h43;
          SEQ_W'(4'b1011): dec_char = 8'h59;
          SEQ_W'(4'b1100): dec_char = 8'h5A;
          SEQ_W'(4'b1101): dec_char = 8'h51;
          default: ;
        endcase
`ifdef MORSE_DIGITS_EN
        LEN_W'(5): case (seq_q)
          SEQ_W'(5'b11111): dec_char = 8'h30;
          SEQ_W'(5'b01111): dec_char = 8'h31;
          SEQ_W'(5'b00111): dec_char = 8'h32;
          SEQ_W'(5'b00011): dec_char = 8'h33;
          SEQ_W'(5'b00001): dec_char = 8'h34;
          SEQ_W'(5'b00000): dec_char = 8'h35;
          SEQ_W'(5'b10000): dec_char = 8'h36;
          SEQ_W'(5'b11000): dec_char = 8'h37;
          SEQ_W'(5'b11100): dec_char = 8'h38;
          SEQ_W'(5'b11110): dec_char = 8'h39;
          default: ;
        endcase
`endif
        default: ;
      endcase
    end
  end

  assign mcnt_inc = (mcnt_q == CNT_MAX) ? mcnt_q : mcnt_q + 1'b1;
  assign gcnt_inc = (gcnt_q == CNT_MAX) ? gcnt_q : gcnt_q + 1'b1;

  // Thresholds compare the count including the current low cycle, so the item
  // is registered on the edge that closes the Nth low cycle.
  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    gcnt_d      = gcnt_q;
    seq_d       = seq_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    word_pend_d = word_pend_q;
    item_vld    = 1'b0;
    item_data   = 8'h00;
    case (state_q)
      S_IDLE: if (key_in) begin
        state_d = S_MARK;
        mcnt_d  = CNT_W'(1);
      end
      S_MARK: if (key_in) begin
        mcnt_d = mcnt_inc;
      end else begin
        state_d = S_GAP;
        gcnt_d  = CNT_W'(1);
        if (len_q < LEN_MAX) begin
          seq_d = {seq_q[SEQ_W-2:0], (mcnt_q >= DASH_TH)};
          len_d = len_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      S_GAP: if (key_in) begin
        state_d     = S_MARK;
        mcnt_d      = CNT_W'(1);
        word_pend_d = 1'b0;
      end else begin
        gcnt_d = gcnt_inc;
        if (gcnt_inc == CHAR_TH && len_q != '0) begin
          item_vld    = 1'b1;
          item_data   = dec_char;
          seq_d       = '0;
          len_d       = '0;
          ovf_d       = 1'b0;
          word_pend_d = 1'b1;
        end else if (gcnt_inc == WORD_TH && word_pend_q) begin
          item_vld    = 1'b1;
          item_data   = 8'h20;
          word_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else if (len_q == '0 && !word_pend_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    char_drop_d  = char_drop_q;
    if (item_vld) begin
      if (!char_valid_q || char_ready) begin
        char_data_d  = item_data;
        char_valid_d = 1'b1;
      end else begin
        char_drop_d = 1'b1;
      end
    end else if (char_valid_q && char_ready) begin
      char_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mcnt_q       <= '0;
      gcnt_q       <= '0;
      seq_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      word_pend_q  <= 1'b0;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      char_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mcnt_q       <= mcnt_d;
      gcnt_q       <= gcnt_d;
      seq_q        <= seq_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      word_pend_q  <= word_pend_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      char_drop_q  <= char_drop_d;
    end
  end

  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign char_drop  = char_drop_q;
endmodule
